// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared encodings for the forwarding/hazard controller: mux select codes and FSM states.
package fwd_pkg;

   localparam logic [1:0] FWD_REG     = 2'd0;
   localparam logic [1:0] FWD_EXALU   = 2'd1;
   localparam logic [1:0] FWD_MEMALU  = 2'd2;
   localparam logic [1:0] FWD_MEMDATA = 2'd3;

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_LSTALL = 2'd1,
      S_MWAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/fwd_hazard_ctrl_sel.sv
// Per-operand forwarding select; also flags a load-use hit on this operand.
module fwd_sel
   import fwd_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] x,
   input  logic          use_x,
   input  logic          ex_wreg,
   input  logic          ex_m2reg,
   input  logic [AW-1:0] ex_wn,
   input  logic          mem_wreg,
   input  logic          mem_m2reg,
   input  logic [AW-1:0] mem_wn,
   output logic [1:0]    sel,
   output logic          lu
);

   always_comb begin
      sel = FWD_REG;
      lu  = 1'b0;
      if (use_x && (x != '0)) begin
         // A load still in EX owns the register: stall instead of taking an older MEM copy.
         if (ex_wreg && (ex_wn == x)) begin
            if (ex_m2reg) lu = 1'b1;
            else          sel = FWD_EXALU;
         end else if (mem_wreg && (mem_wn == x)) begin
            sel = mem_m2reg ? FWD_MEMDATA : FWD_MEMALU;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline.
// Optional stall cycle counter built when STALL_COUNT_EN is defined.
//
// state    | meaning
// S_RUN    | normal flow, hazards checked every cycle
// S_LSTALL | one bubble inserted behind a load; load now in MEM
// S_MWAIT  | data memory busy, whole pipeline frozen
module fwd_hazard_ctrl
   import fwd_pkg::*;
#(
   parameter int AW    = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    id_rs,
   input  logic [AW-1:0]    id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wreg,
   input  logic [AW-1:0]    id_wn,
   input  logic             id_m2reg,
   input  logic             id_wmem,
   input  logic             mem_ready,
   output logic [1:0]       fwda,
   output logic [1:0]       fwdb,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             idex_we,
`ifdef STALL_COUNT_EN
   output logic [CNT_W-1:0] stall_cycles,
`endif
   output logic             idex_bubble
);

   state_t        state, state_nxt;
   logic          ex_wreg, ex_m2reg, ex_mem;
   logic [AW-1:0] ex_wn;
   logic          mem_wreg, mem_m2reg, mem_mem;
   logic [AW-1:0] mem_wn;
   logic [1:0]    sel_a, sel_b;
   logic          lu_a, lu_b, lu, mw;

   fwd_sel #(.AW(AW)) u_sel_rs (
      .x(id_rs), .use_x(id_use_rs),
      .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wn(ex_wn),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wn(mem_wn),
      .sel(sel_a), .lu(lu_a)
   );

   fwd_sel #(.AW(AW)) u_sel_rt (
      .x(id_rt), .use_x(id_use_rt),
      .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wn(ex_wn),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wn(mem_wn),
      .sel(sel_b), .lu(lu_b)
   );

   assign lu   = lu_a | lu_b;
   assign mw   = mem_mem & ~mem_ready;
   assign fwda = rst ? FWD_REG : sel_a;
   assign fwdb = rst ? FWD_REG : sel_b;

   always_ff @(posedge clk) begin
      if (rst) state <= S_RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      idex_bubble = 1'b0;
      if (rst) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
         state_nxt   = S_RUN;
      end else begin
         case (state)
            S_RUN, S_MWAIT, S_LSTALL: begin
               if (mw) begin
                  pc_we     = 1'b0;
                  ifid_we   = 1'b0;
                  idex_we   = 1'b0;
                  state_nxt = S_MWAIT;
               end else if (lu) begin
                  pc_we       = 1'b0;
                  ifid_we     = 1'b0;
                  idex_bubble = 1'b1;
                  // Leaving MWAIT or LSTALL always returns to RUN, even with a bubble.
                  state_nxt   = (state == S_RUN) ? S_LSTALL : S_RUN;
               end else begin
                  state_nxt = S_RUN;
               end
            end
            default: state_nxt = S_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_wreg   <= 1'b0;
         ex_m2reg  <= 1'b0;
         ex_mem    <= 1'b0;
         ex_wn     <= '0;
         mem_wreg  <= 1'b0;
         mem_m2reg <= 1'b0;
         mem_mem   <= 1'b0;
         mem_wn    <= '0;
      end else if (idex_we) begin
         mem_wreg  <= ex_wreg;
         mem_m2reg <= ex_m2reg;
         mem_mem   <= ex_mem;
         mem_wn    <= ex_wn;
         if (idex_bubble) begin
            ex_wreg  <= 1'b0;
            ex_m2reg <= 1'b0;
            ex_mem   <= 1'b0;
            ex_wn    <= '0;
         end else begin
            ex_wreg  <= id_wreg;
            ex_m2reg <= id_m2reg;
            ex_mem   <= id_m2reg | id_wmem;
            ex_wn    <= id_wn;
         end
      end
   end

`ifdef STALL_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) stall_cycles <= '0;
      else if (!pc_we && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
   end
`else
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed pipeline scenarios plus random traffic
// compared with an in-flight instruction model.
module tb_fwd_hazard_ctrl;
   import fwd_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, id_wn;
   logic       id_use_rs, id_use_rt, id_wreg, id_m2reg, id_wmem, mem_ready;
   logic [1:0] fwda, fwdb;
   logic       pc_we, ifid_we, idex_we, idex_bubble;
`ifdef STALL_COUNT_EN
   logic [31:0] stall_cycles;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.AW(5), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_wreg(id_wreg), .id_wn(id_wn), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
      .mem_ready(mem_ready),
      .fwda(fwda), .fwdb(fwdb), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
`ifdef STALL_COUNT_EN
      .stall_cycles(stall_cycles),
`endif
      .idex_bubble(idex_bubble)
   );

   // In-flight instructions: index 0 = EX (youngest), 1 = MEM.
   typedef struct packed {
      logic       wreg;
      logic       load;
      logic       memop;
      logic [4:0] wn;
   } instr_t;

   instr_t      inflight [2];
   longint      m_cnt;

   function automatic logic m_mw();
      return inflight[1].memop && !mem_ready;
   endfunction

   function automatic logic m_lu();
      logic hit = 1'b0;
      if (inflight[0].wreg && inflight[0].load && inflight[0].wn != 0) begin
         if (id_use_rs && id_rs == inflight[0].wn) hit = 1'b1;
         if (id_use_rt && id_rt == inflight[0].wn) hit = 1'b1;
      end
      return hit;
   endfunction

   // Youngest in-flight writer of x supplies the operand; a load in EX cannot yet.
   function automatic logic [1:0] m_fwd(input logic [4:0] x, input logic use_x);
      if (rst || !use_x || x == 0) return 2'd0;
      for (int s = 0; s < 2; s++) begin
         if (inflight[s].wreg && inflight[s].wn == x) begin
            if (s == 0) return inflight[s].load ? 2'd0 : 2'd1;
            return inflight[s].load ? 2'd3 : 2'd2;
         end
      end
      return 2'd0;
   endfunction

   function automatic logic m_pc_we();
      return !rst && !m_mw() && !m_lu();
   endfunction

   function automatic logic m_idex_we();
      return rst || !m_mw();
   endfunction

   function automatic logic m_bubble();
      return rst || (!m_mw() && m_lu());
   endfunction

   task automatic model_update();
      logic stalled;
      logic frozen;
      logic bub;
      stalled = !m_pc_we();
      frozen  = m_mw();
      bub     = m_lu();
      if (rst) begin
         inflight[0] = '0;
         inflight[1] = '0;
         m_cnt = 0;
      end else begin
         if (!frozen) begin
            inflight[1] = inflight[0];
            inflight[0] = bub ? instr_t'(0)
                              : instr_t'{id_wreg, id_m2reg, id_m2reg | id_wmem, id_wn};
         end
         if (stalled && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic wreg, input logic [4:0] wn,
                         input logic m2reg, input logic wmem);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_wreg = wreg; id_wn = wn; id_m2reg = m2reg; id_wmem = wmem;
   endtask

   task automatic nop();
      set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; mem_ready = 1'b1; nop();
      tick(); tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_ready = 1'b1;
      set_id(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
      #1;
      checks++;
      if ({pc_we, ifid_we, idex_we, idex_bubble} !== 4'b0011) begin
         errors++;
         $display("FAIL reset_we got=%b exp=0011", {pc_we, ifid_we, idex_we, idex_bubble});
      end
      checks++;
      if ({fwda, fwdb} !== 4'b0000) begin
         errors++; $display("FAIL reset_fwd got=%b exp=0000", {fwda, fwdb});
      end
      tick(); tick();
      rst = 1'b0; nop();
      #1;
      checks++;
      if ({pc_we, ifid_we, idex_we, idex_bubble} !== 4'b1110) begin
         errors++;
         $display("FAIL reset_release got=%b exp=1110", {pc_we, ifid_we, idex_we, idex_bubble});
      end
`ifdef STALL_COUNT_EN
      checks++;
      if (stall_cycles !== 32'd0) begin
         errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles);
      end
`endif
      tick();
   endtask

   task automatic test_ex_forward();
      do_reset();
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
      tick();
      set_id(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
      #1;
      checks++;
      if ({fwda, fwdb, pc_we, idex_bubble} !== 6'b01_00_1_0) begin
         errors++;
         $display("FAIL ex_fwd got fwda=%0d fwdb=%0d pc_we=%b bub=%b exp 1 0 1 0",
                  fwda, fwdb, pc_we, idex_bubble);
      end
      tick();
   endtask

   task automatic test_mem_forward();
      do_reset();
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
      tick();
      nop(); tick();
      set_id(5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      #1;
      checks++;
      if ({fwda, fwdb} !== 4'b00_10) begin
         errors++; $display("FAIL mem_fwd got fwda=%0d fwdb=%0d exp 0 2", fwda, fwdb);
      end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
      tick();
      set_id(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
      #1;
      checks++;
      if ({pc_we, ifid_we, idex_we, idex_bubble, fwda, fwdb} !== 8'b0011_0000) begin
         errors++;
         $display("FAIL lu_stall got we/bub=%b fwd=%0d,%0d exp 0011 0,0",
                  {pc_we, ifid_we, idex_we, idex_bubble}, fwda, fwdb);
      end
      tick();
      #1;
      checks++;
      if (dut.state !== S_LSTALL) begin
         errors++; $display("FAIL lu_state got=%0d exp=%0d", dut.state, S_LSTALL);
      end
      checks++;
      if ({fwda, fwdb, pc_we, idex_bubble} !== 6'b11_11_1_0) begin
         errors++;
         $display("FAIL lu_resolve got fwda=%0d fwdb=%0d pc_we=%b bub=%b exp 3 3 1 0",
                  fwda, fwdb, pc_we, idex_bubble);
      end
      tick();
   endtask

   task automatic test_mem_wait();
      do_reset();
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0);
      tick();
      nop(); tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({pc_we, ifid_we, idex_we, idex_bubble} !== 4'b0000) begin
            errors++;
            $display("FAIL mwait_freeze cyc=%0d got=%b exp=0000", i,
                     {pc_we, ifid_we, idex_we, idex_bubble});
         end
         tick();
      end
`ifdef STALL_COUNT_EN
      checks++;
      if (stall_cycles !== 32'd3) begin
         errors++; $display("FAIL mwait_cnt got=%0d exp=3", stall_cycles);
      end
`endif
      mem_ready = 1'b1;
      #1;
      checks++;
      if ({pc_we, ifid_we, idex_we, idex_bubble} !== 4'b1110) begin
         errors++;
         $display("FAIL mwait_release got=%b exp=1110", {pc_we, ifid_we, idex_we, idex_bubble});
      end
      tick();
   endtask

   task automatic test_dest_zero_and_priority();
      do_reset();
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      tick();
      set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
      #1;
      checks++;
      if ({fwda, fwdb} !== 4'b0000) begin
         errors++; $display("FAIL dest_zero got fwda=%0d fwdb=%0d exp 0 0", fwda, fwdb);
      end
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
      tick();
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
      tick();
      set_id(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
      #1;
      checks++;
      if ({fwda, fwdb} !== 4'b01_01) begin
         errors++; $display("FAIL ex_priority got fwda=%0d fwdb=%0d exp 1 1", fwda, fwdb);
      end
      tick();
   endtask

   task automatic test_reset_in_mwait();
      do_reset();
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0);
      tick();
      nop(); tick();
      mem_ready = 1'b0;
      tick();
      #1;
      checks++;
      if (dut.state !== S_MWAIT) begin
         errors++; $display("FAIL rst_mwait_enter got=%0d exp=%0d", dut.state, S_MWAIT);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({pc_we, ifid_we, idex_we, idex_bubble} !== 4'b0011) begin
         errors++;
         $display("FAIL rst_mwait_hold got=%b exp=0011", {pc_we, ifid_we, idex_we, idex_bubble});
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (dut.state !== S_RUN || {pc_we, ifid_we, idex_we, idex_bubble} !== 4'b1110) begin
         errors++;
         $display("FAIL rst_mwait_after got state=%0d we=%b exp state=%0d we=1110",
                  dut.state, {pc_we, ifid_we, idex_we, idex_bubble}, S_RUN);
      end
      mem_ready = 1'b1;
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 39) == 0);
         mem_ready = ($urandom_range(0, 3) != 0);
         id_rs     = 5'($urandom_range(0, 3));
         id_rt     = 5'($urandom_range(0, 3));
         id_wn     = 5'($urandom_range(0, 3));
         id_use_rs = 1'($urandom_range(0, 1));
         id_use_rt = 1'($urandom_range(0, 1));
         id_wreg   = 1'($urandom_range(0, 1));
         id_m2reg  = ($urandom_range(0, 2) == 0);
         id_wmem   = !id_m2reg && ($urandom_range(0, 3) == 0);
         #1;
         checks++;
         if (fwda !== m_fwd(id_rs, id_use_rs) || fwdb !== m_fwd(id_rt, id_use_rt)) begin
            errors++;
            $display("FAIL rnd_fwd n=%0d got %0d,%0d exp %0d,%0d", n, fwda, fwdb,
                     m_fwd(id_rs, id_use_rs), m_fwd(id_rt, id_use_rt));
         end
         checks++;
         if ({pc_we, ifid_we, idex_we, idex_bubble} !==
             {m_pc_we(), m_pc_we(), m_idex_we(), m_bubble()}) begin
            errors++;
            $display("FAIL rnd_ctl n=%0d got=%b exp=%b", n,
                     {pc_we, ifid_we, idex_we, idex_bubble},
                     {m_pc_we(), m_pc_we(), m_idex_we(), m_bubble()});
         end
`ifdef STALL_COUNT_EN
         checks++;
         if (stall_cycles !== 32'(m_cnt)) begin
            errors++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, stall_cycles, m_cnt);
         end
`endif
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      inflight[0] = '0;
      inflight[1] = '0;
      m_cnt = 0;
      rst = 1'b1; mem_ready = 1'b1; nop();
      @(negedge clk);
      test_reset();
      test_ex_forward();
      test_mem_forward();
      test_load_use();
      test_mem_wait();
      test_dest_zero_and_priority();
      test_reset_in_mwait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
